mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-port unified instruction/data memory between the pipeline's fetch stage and memory stage. Grants one request at a time and drives the memory-side enable, address and write controls. Returns read data and a one-cycle acknowledge to the winning requester, which the hazard unit uses as its stall release. It sits between the SCPU core ports (PC/instruction and Addr/Data/mem_w) and the DM-style synchronous memory.

## Interface
Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while a fetch waits; range 1–15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction; registered; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; registered; valid while dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe.
- mem_w  out  1  memory write enable; only meaningful when mem_en=1.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory completion (MIO_ready); used only under MEM_WAIT_EN.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE with no eligible request: stay.
- IDLE with a request: choose a winner, latch its address, we and wdata into the mem_* registers, go to BUSY_I or BUSY_D.
- Port eligibility: a port is ineligible in any cycle where its own ack is high. Requesters drop or change req the cycle after ack, so the ack cycle never re-issues.
- Priority: dm_req wins over if_req, because the memory-stage instruction is older.
- Exception: when starve_cnt == STARVE_MAX and if_req is eligible, the fetch wins.
- starve_cnt: 4-bit counter.
  - +1 on each data grant made while if_req=1.
  - Cleared on any fetch grant, or in any cycle where if_req=0.
  - Saturates at STARVE_MAX.
- BUSY_x: mem_en=1 and the mem_* outputs are stable for the whole access.
- Completion:
  - Capture mem_rdata into if_rdata or dm_rdata; for a store, dm_rdata holds its previous value.
  - Pulse the matching ack in the next cycle.
  - Return to IDLE; mem_en=0 in the ack cycle.
- Request inputs are ignored while in BUSY_x. Changes to addr or wdata during BUSY_x have no effect.
- Reset values: state=IDLE; mem_en=0; mem_w=0; mem_addr=0; mem_wdata=0; if_ack=0; dm_ack=0; if_rdata=0; dm_rdata=0; starve_cnt=0.
- Reset asserted mid-access: the access is aborted, no ack is issued, and all outputs take their reset values on that edge.

## Timing
- Request sampled in IDLE at edge N.
- mem_en high in cycle N+1 through the completion cycle.
- Fixed latency (macro off): ack high in cycle N+2, so 2 cycles from req to ack.
- Back-to-back: the next grant can be made in the ack cycle (the other port only), so mem_en can rise again in cycle N+3.
- Simultaneous if_req and dm_req in IDLE: data served first. The fetch is granted in the data ack cycle, unless a new dm_req appears there and starvation is not reached.
- mem_w is asserted only when mem_en=1.

## Configuration
- MEM_WAIT_EN defined:
  - BUSY_x holds until mem_ready=1 is sampled; completion happens at that edge, and the ack follows in the next cycle.
  - mem_ready is ignored outside BUSY_x.
- MEM_WAIT_EN undefined:
  - mem_ready is unused; every access completes after exactly one mem_en cycle.

## Structure
- Shared package mips_mem_pkg holds:
  - State enum (IDLE, BUSY_I, BUSY_D).
  - Port-select constants (SEL_IF, SEL_DM).
  - STARVE_CNT_W = 4.
- One sub-module, mem_arb_prio: purely combinational winner selection.
  - Inputs: if_req, dm_req, both acks, starve_cnt, STARVE_MAX.
  - Outputs: grant valid and grant select.
- FSM, counter and registers live in mem_arbiter.

## Test plan
- Reset mid-access: assert reset while in BUSY_D with dm_we=1 → no dm_ack; mem_en=0 and mem_w=0 the next cycle; state IDLE.
- Single fetch, if_addr=0x0000_0040, memory returns 0x2008_0005 → mem_en in cycle 1, if_ack and if_rdata=0x2008_0005 in cycle 2.
- Simultaneous requests: load at 0x100 plus fetch at 0x44 → dm served first (dm_ack cycle 2), mem_addr=0x44 in cycle 3, if_ack cycle 4.
- Starvation: if_req held while dm_req is re-raised after every ack, STARVE_MAX=4 → exactly 4 data grants, then a fetch grant; starve_cnt returns to 0.
- MEM_WAIT_EN, store: 0xDEAD_BEEF to 0x200 with mem_ready low for 3 cycles → mem_en/mem_w held for 4 cycles, dm_ack one cycle after mem_ready, dm_rdata unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   SEL_IF/SEL_DM: port-select encoding produced by the priority logic
//   STARVE_CNT_W : width of the fetch-starvation counter
package mips_mem_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational winner selection for the memory arbiter.
// Ports:
//   if_req, dm_req  : raw requests from fetch and memory stage
//   if_ack, dm_ack  : current acknowledge pulses (a port is not eligible
//                     in its own ack cycle)
//   starve_cnt      : consecutive data grants made while a fetch waited
//   gnt_vld         : some port is eligible
//   gnt_sel         : winning port (SEL_IF / SEL_DM)
// Parameter STARVE_MAX: starvation threshold at which the fetch wins.
module mem_arb_prio
  import mips_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                    if_req,
  input  logic                    dm_req,
  input  logic                    if_ack,
  input  logic                    dm_ack,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output logic                    gnt_vld,
  output logic                    gnt_sel
);

  logic if_elig;
  logic dm_elig;
  logic starved;

  always_comb begin
    if_elig = if_req & ~if_ack;
    dm_elig = dm_req & ~dm_ack;
    starved = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
    gnt_vld = if_elig | dm_elig;
    // Data is older in the pipeline and normally wins, except when the
    // fetch has waited through STARVE_MAX data grants.
    gnt_sel = SEL_IF;
    if (dm_elig && !(starved && if_elig)) begin
      gnt_sel = SEL_DM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified instruction/data memory shared by
// the fetch stage (if_*) and the memory stage (dm_*). One access at a time;
// the winner gets a registered read-data word and a one-cycle ack.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   if_req/if_addr               : fetch request and byte address
//   if_rdata/if_ack              : fetched word and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata: load/store request
//   dm_rdata/dm_ack              : load data and completion pulse
//   mem_en/mem_w/mem_addr/mem_wdata : registered memory-side controls
//   mem_rdata                    : memory read data
//   mem_ready                    : memory completion, used only when
//                                  MEM_WAIT_EN is defined
// Build option MEM_WAIT_EN: accesses stay busy until mem_ready is sampled
// high; otherwise every access takes exactly one mem_en cycle.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_en,
  output logic        mem_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  arb_state_t              state;
  arb_state_t              state_nxt;
  logic                    gnt_vld;
  logic                    gnt_sel;
  logic                    do_grant;
  logic                    done;
  logic                    access_done;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic [STARVE_CNT_W-1:0] starve_nxt;

  function automatic logic [STARVE_CNT_W-1:0] sat_inc(
    input logic [STARVE_CNT_W-1:0] v
  );
    if (v == STARVE_CNT_W'(STARVE_MAX)) return v;
    return v + 1'b1;
  endfunction

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .if_ack     (if_ack),
    .dm_ack     (dm_ack),
    .starve_cnt (starve_cnt),
    .gnt_vld    (gnt_vld),
    .gnt_sel    (gnt_sel)
  );

`ifdef MEM_WAIT_EN
  assign access_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign access_done      = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    done       = 1'b0;
    starve_nxt = starve_cnt;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          do_grant  = 1'b1;
          state_nxt = (gnt_sel == SEL_DM) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (access_done) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Count data grants only while a fetch is actually waiting.
    if ((do_grant && gnt_sel == SEL_IF) || !if_req) begin
      starve_nxt = '0;
    end else if (do_grant && gnt_sel == SEL_DM) begin
      starve_nxt = sat_inc(starve_cnt);
    end
  end

  // Grant stage: latch the winner into mem_*; completion stage: capture
  // read data and pulse the ack one cycle after the access ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_en     <= 1'b0;
      mem_w      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if (do_grant) begin
        mem_en   <= 1'b1;
        mem_w    <= (gnt_sel == SEL_DM) && dm_we;
        mem_addr <= (gnt_sel == SEL_DM) ? dm_addr : if_addr;
        if (gnt_sel == SEL_DM) begin
          mem_wdata <= dm_wdata;
        end
      end else if (done) begin
        mem_en <= 1'b0;
        mem_w  <= 1'b0;
        if (state == BUSY_I) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          dm_ack <= 1'b1;
          // A store leaves the last load result in place.
          if (!mem_w) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run scored against a transaction-timeline model.
module tb_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_w;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        ovr_en;
  logic [31:0] ovr_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_en    (mem_en),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = ovr_en ? ovr_data : mem_fn(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model state: index 0 = fetch port, 1 = data port.
  logic        m_pend  [2];
  int          m_ackc  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        m_we    [2];
  int          m_cur_port;
  int          m_cur_cyc;
  int          m_free_at;
  int          m_cnt;
  logic [31:0] m_if_rd;
  logic [31:0] m_dm_rd;

  task automatic run_model(input int ncyc);
    int p_if, p_dm, w;
    logic exp_en, exp_w, busy;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 120)            begin p_if = 100; p_dm = 100; end
      else if (c < 500)       begin p_if = 60;  p_dm = 60;  end
      else if (c < ncyc - 20) begin p_if = 30;  p_dm = 85;  end
      else                    begin p_if = 0;   p_dm = 0;   end

      // Outputs expected in this cycle.
      if (m_ackc[0] == c) m_if_rd = mem_fn(m_addr[0]);
      if (m_ackc[1] == c && !m_we[1]) m_dm_rd = mem_fn(m_addr[1]);
      exp_en = (m_cur_port >= 0) && (m_cur_cyc + 1 == c);
      exp_w  = exp_en && (m_cur_port == 1) && m_we[1];
      check("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
      check("mem_w", {31'd0, mem_w}, {31'd0, exp_w});
      if (exp_en) begin
        check("mem_addr", mem_addr, m_addr[m_cur_port]);
        if (exp_w) check("mem_wdata", mem_wdata, m_wdata[1]);
      end
      check("if_ack", {31'd0, if_ack}, {31'd0, m_ackc[0] == c});
      check("dm_ack", {31'd0, dm_ack}, {31'd0, m_ackc[1] == c});
      check("if_rdata", if_rdata, m_if_rd);
      check("dm_rdata", dm_rdata, m_dm_rd);
      check("starve_cnt", 32'(dut.starve_cnt), 32'(m_cnt));

      // Requesters: hold through the ack cycle, then maybe issue anew.
      for (int i = 0; i < 2; i++) begin
        busy = m_pend[i] || (m_ackc[i] >= c);
        if (!busy && $urandom_range(99) < ((i == 0) ? p_if : p_dm)) begin
          m_pend[i]  = 1'b1;
          m_addr[i]  = $urandom() & 32'hFFFF_FFFC;
          m_wdata[i] = $urandom();
          m_we[i]    = (i == 1) ? 1'($urandom_range(1)) : 1'b0;
        end
      end
      if_req   = m_pend[0] || (m_ackc[0] >= c);
      dm_req   = m_pend[1] || (m_ackc[1] >= c);
      dm_we    = m_we[1];
      // While an access is in flight, its requester's fields are scrambled.
      if_addr  = (m_ackc[0] == c + 1) ? $urandom() : m_addr[0];
      dm_addr  = (m_ackc[1] == c + 1) ? $urandom() : m_addr[1];
      dm_wdata = (m_ackc[1] == c + 1) ? $urandom() : m_wdata[1];

      // Arbitration decided at the end of this cycle.
      w = -1;
      if (c >= m_free_at) begin
        if (m_pend[0] && m_pend[1]) w = (m_cnt == STARVE_MAX) ? 0 : 1;
        else if (m_pend[1])         w = 1;
        else if (m_pend[0])         w = 0;
      end
      if (w == 0 || !if_req) m_cnt = 0;
      else if (w == 1 && m_cnt < STARVE_MAX) m_cnt = m_cnt + 1;
      if (w >= 0) begin
        m_pend[w]  = 1'b0;
        m_ackc[w]  = c + 2;
        m_cur_port = w;
        m_cur_cyc  = c;
        m_free_at  = c + 2;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_ready = 1'b1; ovr_en = 1'b0;
    ovr_data = '0;
    step();
    step();
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_w", {31'd0, mem_w}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_starve", 32'(dut.starve_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Single fetch; request stays high through the ack cycle.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    ovr_en = 1'b1; ovr_data = 32'h2008_0005;
    step();
    check("sf_c1_mem_en", {31'd0, mem_en}, 32'd1);
    check("sf_c1_addr", mem_addr, 32'h0000_0040);
    check("sf_c1_mem_w", {31'd0, mem_w}, 32'd0);
    check("sf_c1_ack", {31'd0, if_ack}, 32'd0);
    step();
    check("sf_c2_ack", {31'd0, if_ack}, 32'd1);
    check("sf_c2_rdata", if_rdata, 32'h2008_0005);
    check("sf_c2_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    if_req = 1'b0; ovr_en = 1'b0;
    check("sf_c3_no_reissue", {31'd0, mem_en}, 32'd0);
    check("sf_c3_ack", {31'd0, if_ack}, 32'd0);
    step();

    // Simultaneous load and fetch: data first, fetch in the data ack cycle.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    step();
    check("sim_c1_addr", mem_addr, 32'h0000_0100);
    check("sim_c1_mem_en", {31'd0, mem_en}, 32'd1);
    step();
    check("sim_c2_dm_ack", {31'd0, dm_ack}, 32'd1);
    check("sim_c2_dm_rdata", dm_rdata, mem_fn(32'h0000_0100));
    check("sim_c2_mem_en", {31'd0, mem_en}, 32'd0);
    check("sim_c2_if_ack", {31'd0, if_ack}, 32'd0);
    step();
    dm_req = 1'b0;
    check("sim_c3_mem_en", {31'd0, mem_en}, 32'd1);
    check("sim_c3_addr", mem_addr, 32'h0000_0044);
    check("sim_c3_dm_ack", {31'd0, dm_ack}, 32'd0);
    step();
    check("sim_c4_if_ack", {31'd0, if_ack}, 32'd1);
    check("sim_c4_if_rdata", if_rdata, mem_fn(32'h0000_0044));
    step();
    if_req = 1'b0;
    check("sim_c5_mem_en", {31'd0, mem_en}, 32'd0);
    step();

    // Store: dm_rdata keeps the previous load result.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0200;
    dm_wdata = 32'hDEAD_BEEF;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) mem_ready = 1'b1;
      check("st_wait_mem_en", {31'd0, mem_en}, 32'd1);
      check("st_wait_mem_w", {31'd0, mem_w}, 32'd1);
      check("st_wait_dm_ack", {31'd0, dm_ack}, 32'd0);
    end
`else
    step();
    check("st_c1_mem_en", {31'd0, mem_en}, 32'd1);
    check("st_c1_mem_w", {31'd0, mem_w}, 32'd1);
`endif
    check("st_addr", mem_addr, 32'h0000_0200);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    check("st_dm_ack", {31'd0, dm_ack}, 32'd1);
    check("st_dm_rdata_hold", dm_rdata, mem_fn(32'h0000_0100));
    check("st_ack_mem_en", {31'd0, mem_en}, 32'd0);
    check("st_ack_mem_w", {31'd0, mem_w}, 32'd0);
    step();
    dm_req = 1'b0;
    step();

    // Reset during a store access.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0300;
    dm_wdata = 32'h1234_5678;
    step();
    check("ra_busy_mem_w", {31'd0, mem_w}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; dm_req = 1'b0;
    check("ra_dm_ack", {31'd0, dm_ack}, 32'd0);
    check("ra_mem_en", {31'd0, mem_en}, 32'd0);
    check("ra_mem_w", {31'd0, mem_w}, 32'd0);
    check("ra_mem_addr", mem_addr, 32'd0);
    check("ra_dm_rdata", dm_rdata, 32'd0);
    check("ra_state", 32'(dut.state), 32'(IDLE));
    step();
    check("ra_no_late_ack", {31'd0, dm_ack}, 32'd0);
    check("ra_idle_mem_en", {31'd0, mem_en}, 32'd0);

    // Randomized run against the timeline model.
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0; m_ackc[i] = -10; m_addr[i] = '0;
      m_wdata[i] = '0; m_we[i] = 1'b0;
    end
    m_cur_port = -1; m_cur_cyc = -10; m_free_at = 0; m_cnt = 0;
    m_if_rd = '0; m_dm_rd = '0;
    run_model(1200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
